// File: rtl/gate2_exerciser.sv
// Drives the four {a,b} vectors into a two-input gate, samples y after a settle
// time and accumulates per-vector mismatches against a truth table.
module gate2_exerciser #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH         = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] vec, vec_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] ab_n;
  logic       busy_n, done_n, pass_n;
  logic [3:0] fail_n;
  logic [2:0] err_n;
  logic       mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= 2'd0;
      cnt      <= 8'd0;
      a_out    <= 1'b0;
      b_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 4'd0;
      err_cnt  <= 3'd0;
    end else begin
      state          <= state_n;
      vec            <= vec_n;
      cnt            <= cnt_n;
      {a_out, b_out} <= ab_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      fail_vec       <= fail_n;
      err_cnt        <= err_n;
    end
  end

  // Case-inequality so an undriven or X gate output is flagged in simulation.
  assign mismatch = (y_in !== TRUTH[vec]);

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    ab_n    = {a_out, b_out};
    pass_n  = pass;
    fail_n  = fail_vec;
    err_n   = err_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          fail_n  = 4'd0;
          err_n   = 3'd0;
          vec_n   = 2'd0;
          ab_n    = 2'b00;
          cnt_n   = RELOAD;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) state_n = SAMPLE;
        else             cnt_n   = cnt - 8'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_n = fail_vec | (4'b0001 << vec);
          err_n  = err_cnt + 3'd1;
        end
        if (vec == 2'd3) begin
          state_n = DONE;
          // Result must already be valid in the DONE cycle.
          pass_n  = (fail_n == 4'd0);
        end else begin
          vec_n   = vec + 2'd1;
          ab_n    = vec + 2'd1;
          cnt_n   = RELOAD;
          state_n = SETTLE;
        end
      end
      DONE: begin
        state_n = IDLE;
        ab_n    = 2'b00;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: doc/gate2_exerciser.md
# gate2_exerciser

Sequential stimulus-and-check stage for two-input gate cells such as the switch-level `nand2`. It drives all four `{a,b}` input vectors into the gate under test in a fixed order. After a programmable settle time it samples the gate's `y` output and compares it against a parameterised truth table. It reports per-vector failures, an error count and a pass flag through a start/done handshake. The block sits on both sides of the gate: its `a_out`/`b_out` feed the gate inputs, and it consumes the gate output on `y_in`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1–255.
- `TRUTH`, default 4'b0111: expected output; bit index = `{a,b}` (NAND: 00→1, 01→1, 10→1, 11→0).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE.
- `y_in`  in  1  output of the gate under test.
- `a_out`  out  1  gate input a (registered).
- `b_out`  out  1  gate input b (registered).
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when `fail_vec == 0` for the last completed run.
- `fail_vec`  out  4  bit k set if vector k (`{a,b}=k`) mismatched.
- `err_cnt`  out  3  mismatch count of the last run (0–4).

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. 2-bit vector index `vec`; 8-bit settle counter `cnt`.
- IDLE, with `start=1`:
  - clear `fail_vec` and `err_cnt`;
  - set `vec=0` and `{a_out,b_out}=2'b00`;
  - load `cnt=SETTLE_CYCLES-1`;
  - go to SETTLE.
- IDLE, with `start=0`: hold all outputs, including the results of the previous run.
- SETTLE: if `cnt==0`, go to SAMPLE; else decrement `cnt`. Vector held constant.
- SAMPLE: compare `y_in` with `TRUTH[vec]`.
  - Mismatch: set `fail_vec[vec]` and increment `err_cnt`. X or Z on `y_in` counts as a mismatch in simulation (case-inequality compare).
  - If `vec==3`, go to DONE.
  - Otherwise increment `vec`, drive `{a_out,b_out}=vec+1`, reload `cnt=SETTLE_CYCLES-1` and go to SETTLE.
- DONE:
  - `done=1`, `busy=1`;
  - `pass` registered as `(fail_vec_next==0)`, including the final SAMPLE's update;
  - next state IDLE;
  - `{a_out,b_out}` returns to 00 on the IDLE entry.
- `start` while not in IDLE is ignored. No queuing and no restart.
- Vector order is fixed: 00, 01, 10, 11.

## Timing
- Reset values: `a_out=0`, `b_out=0`, `busy=0`, `done=0`, `pass=0`, `fail_vec=0`, `err_cnt=0`, state=IDLE.
- Reset asserted mid-run aborts the run immediately. The next cycle shows all reset values. No `done` pulse.
- Accepted `start` at edge 0:
  - vector 00 and `busy=1` are visible from cycle 1;
  - vector k is driven during cycles `1+k(S+1)` … `(k+1)(S+1)`, with S=`SETTLE_CYCLES`;
  - vector k is sampled in cycle `(k+1)(S+1)`.
- `done` is high in cycle `4(S+1)+1`. With S=2, that is cycle 13.
- `pass`, `fail_vec` and `err_cnt` are final and stable from the `done` cycle until the next accepted `start`.
- `start` held high continuously: a new run is accepted in the first IDLE cycle after DONE, i.e. one idle cycle between runs.
- `y_in` is sampled combinationally in SAMPLE. The gate under test must settle within S cycles of the vector change.

## Test plan
- Correct nand2, defaults, `start` pulse at cycle 0:
  - `a_out/b_out` sequence 00,01,10,11, each held 3 cycles;
  - `done` at cycle 13, `pass=1`, `fail_vec=0000`, `err_cnt=0`.
- `y_in` tied 1, TRUTH=0111:
  - `fail_vec=1000`, `err_cnt=1`, `pass=0`.
- `y_in` tied 0:
  - `fail_vec=0111`, `err_cnt=3`, `pass=0`;
  - a second run with a correct nand2 clears to `fail_vec=0000`, `pass=1`.
- SETTLE_CYCLES=1:
  - each vector held 2 cycles;
  - `done` at cycle 9;
  - `start` pulsed during the run has no effect (`done` still at 9, single pulse).
- `rst` asserted at cycle 5 of a run:
  - next cycle all outputs are zero, state IDLE, no `done`;
  - a fresh `start` completes normally.
- `y_in` driven X during vector 10 only:
  - `fail_vec=0100`, `err_cnt=1`.
